// File: rtl/featuremap_pkg.sv
// featuremap_pkg: fp32 field constants and sign-magnitude compare helpers,
// shared by the conv2d, add_bias and maxpool feature-map blocks.
package featuremap_pkg;

   localparam int SIGN_BIT = 31;
   localparam int MAG_MSB  = 30;

   typedef logic [31:0] fp32_t;

   // Strict a > b on raw fp32 bits; +0 and -0 compare equal, NaN/Inf undefined.
   function automatic logic fp32_gt(input logic [31:0] a, input logic [31:0] b);
      return (a[SIGN_BIT] ^ b[SIGN_BIT]) ? (!a[SIGN_BIT] && (|{a[MAG_MSB:0], b[MAG_MSB:0]})) :
             a[SIGN_BIT]                 ? (a[MAG_MSB:0] < b[MAG_MSB:0]) :
                                           (a[MAG_MSB:0] > b[MAG_MSB:0]);
   endfunction

   function automatic logic [31:0] fp32_relu(input logic [31:0] a);
      return a[SIGN_BIT] ? 32'h0 : a;
   endfunction

endpackage

// File: rtl/featuremap_maxpool2x2_fp32_max2.sv
// fp32_max2: combinational 2-input fp32 max; ties return the first operand.
module fp32_max2
   import featuremap_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   assign y = fp32_gt(b, a) ? b : a;

endmodule

// File: rtl/featuremap_maxpool2x2.sv
// featuremap_maxpool2x2: streaming 2x2/stride-2 fp32 max-pool over a WIDTH x HEIGHT raster.
// Define FEATUREMAP_POOL_RELU_EN to apply ReLU to data_in ahead of pooling.
module featuremap_maxpool2x2
   import featuremap_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 56,
   parameter int HEIGHT     = 56
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam int LW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

   generate
      if ((WIDTH % 2) != 0 || (HEIGHT % 2) != 0) begin : g_odd_dims
         $error("featuremap_maxpool2x2: WIDTH and HEIGHT must be even");
      end
   endgenerate

   logic [CW-1:0]         col_cnt;
   logic [RW-1:0]         row_cnt;
   logic [DATA_WIDTH-1:0] hmax_q;
   logic [DATA_WIDTH-1:0] linebuf [WIDTH/2];
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] win_hi;
   logic [DATA_WIDTH-1:0] win_max;
   logic [LW-1:0]         lb_idx;
   logic                  col_last;
   logic                  row_last;

`ifdef FEATUREMAP_POOL_RELU_EN
   assign din = fp32_relu(data_in);
`else
   assign din = data_in;
`endif

   assign lb_idx   = LW'(col_cnt >> 1);
   assign col_last = col_cnt == CW'(WIDTH - 1);
   assign row_last = row_cnt == RW'(HEIGHT - 1);

   fp32_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_pair (.a(hmax_q),          .b(din), .y(pair_max));
   fp32_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_hi   (.a(linebuf[lb_idx]), .b(hmax_q), .y(win_hi));
   fp32_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_win  (.a(win_hi),          .b(din), .y(win_max));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_cnt    <= '0;
         row_cnt    <= '0;
         hmax_q     <= '0;
         valid_out  <= 1'b0;
         data_out   <= '0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in) begin
            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            if (col_last)
               row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            if (!col_cnt[0])
               hmax_q <= din;
            if (col_cnt[0] && row_cnt[0]) begin
               data_out   <= win_max;
               valid_out  <= 1'b1;
               frame_done <= row_last && col_last;
            end
         end
      end
   end

   // Even rows always rewrite an entry before the odd row reads it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (valid_in && col_cnt[0] && !row_cnt[0])
         linebuf[lb_idx] <= pair_max;
   end

endmodule
